// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the RV32I pipeline datapath and its hazard controller.
// The datapath side (master) presents the IF/ID instruction and the stall/flush
// causes; the controller side (slave) returns enables, flushes, forwarding
// selects, scoreboard visibility and performance counters.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_instr;
  logic             id_valid;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_en;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             ex_valid;
  logic             mem_valid;
  logic             wb_valid;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_instr, id_valid, ex_branch_taken, mem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_flush, pipe_en,
    input  fwd_a, fwd_b, ex_valid, mem_valid, wb_valid,
    input  stall_count, flush_count
  );

  modport slave (
    input  id_instr, id_valid, ex_branch_taken, mem_busy,
    output pc_en, ifid_en, ifid_flush, idex_flush, pipe_en,
    output fwd_a, fwd_b, ex_valid, mem_valid, wb_valid,
    output stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard / sequencing controller for a 5-stage RV32I pipeline.
// Tracks the instructions in EX, MEM and WB in a small scoreboard and derives
// pipeline enables, bubble insertion, EX operand forwarding and saturating
// stall/flush counters. Priority per cycle: memory freeze, taken branch,
// load-use stall, normal advance.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Decoded IF/ID fields
  logic [6:0] opcode;
  logic [4:0] id_rd;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       writes_rd;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       is_load;

  // Scoreboard: EX stage entry
  logic       ex_valid;
  logic [4:0] ex_rd;
  logic [4:0] ex_rs1;
  logic [4:0] ex_rs2;
  logic       ex_wr;
  logic       ex_ld;

  // Scoreboard: MEM stage entry
  logic       mem_valid;
  logic [4:0] mem_rd;
  logic       mem_wr;
  logic       mem_ld;

  // Scoreboard: WB stage entry
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       wb_wr;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic load_use;
  logic take_branch;
  logic advance;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Forwarding source for one EX operand; the younger MEM result wins over WB.
  // A load in MEM has no data yet, so it never forwards from that stage.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (ex_valid && mem_valid && mem_wr && !mem_ld && (mem_rd == rs))
      return FWD_MEM;
    if (ex_valid && wb_valid && wb_wr && (wb_rd == rs))
      return FWD_WB;
    return FWD_RF;
  endfunction

  assign opcode = hz.id_instr[6:0];
  assign id_rd  = hz.id_instr[11:7];
  assign id_rs1 = hz.id_instr[19:15];
  assign id_rs2 = hz.id_instr[24:20];

  // Classify the IF/ID instruction by which register ports it touches.
  always_comb begin
    writes_rd = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    is_load   = 1'b0;
    case (opcode)
      7'b0110011: begin writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0010011: begin writes_rd = 1'b1; uses_rs1 = 1'b1; end
      7'b0000011: begin writes_rd = 1'b1; uses_rs1 = 1'b1; is_load = 1'b1; end
      7'b0110111: writes_rd = 1'b1;
      7'b0010111: writes_rd = 1'b1;
      7'b1101111: writes_rd = 1'b1;
      7'b1100111: begin writes_rd = 1'b1; uses_rs1 = 1'b1; end
      7'b0100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b1100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      default: ;
    endcase
  end

  // A load in EX whose destination feeds the instruction in ID cannot be
  // forwarded in time; ex_wr is already cleared for rd = x0.
  assign load_use = hz.id_valid && ex_valid && ex_ld && ex_wr &&
                    ((uses_rs1 && (id_rs1 == ex_rd)) ||
                     (uses_rs2 && (id_rs2 == ex_rd)));

  assign advance     = !hz.mem_busy;
  assign take_branch = advance && hz.ex_branch_taken;

  // Same-cycle enables and flushes in priority order.
  always_comb begin
    hz.pc_en      = 1'b1;
    hz.ifid_en    = 1'b1;
    hz.ifid_flush = 1'b0;
    hz.idex_flush = 1'b0;
    hz.pipe_en    = 1'b1;
    if (hz.mem_busy) begin
      hz.pc_en   = 1'b0;
      hz.ifid_en = 1'b0;
      hz.pipe_en = 1'b0;
    end else if (hz.ex_branch_taken) begin
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (load_use) begin
      hz.pc_en      = 1'b0;
      hz.ifid_en    = 1'b0;
      hz.idex_flush = 1'b1;
    end
  end

  assign hz.fwd_a       = fwd_sel(ex_rs1);
  assign hz.fwd_b       = fwd_sel(ex_rs2);
  assign hz.ex_valid    = ex_valid;
  assign hz.mem_valid   = mem_valid;
  assign hz.wb_valid    = wb_valid;
  assign hz.stall_count = stall_cnt;
  assign hz.flush_count = flush_cnt;

  // Scoreboard shift (ID -> EX -> MEM -> WB) and counters; all hold on freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_wr     <= 1'b0;
      ex_ld     <= 1'b0;
      mem_valid <= 1'b0;
      mem_rd    <= '0;
      mem_wr    <= 1'b0;
      mem_ld    <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_wr     <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (advance) begin
      // MEM -> WB boundary
      wb_valid  <= mem_valid;
      wb_rd     <= mem_rd;
      wb_wr     <= mem_wr;
      // EX -> MEM boundary
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_wr    <= ex_wr;
      mem_ld    <= ex_ld;
      // ID -> EX boundary: bubble on branch flush or load-use stall
      if (take_branch || load_use) begin
        ex_valid <= 1'b0;
        ex_rd    <= '0;
        ex_rs1   <= '0;
        ex_rs2   <= '0;
        ex_wr    <= 1'b0;
        ex_ld    <= 1'b0;
      end else begin
        ex_valid <= hz.id_valid;
        ex_rd    <= id_rd;
        ex_rs1   <= id_rs1;
        ex_rs2   <= id_rs2;
        ex_wr    <= writes_rd && (id_rd != 5'd0);
        ex_ld    <= is_load;
      end
      if (take_branch)
        flush_cnt <= sat_inc(flush_cnt);
      else if (load_use)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: RAW forwarding, load-use stall,
// x0 destination, branch vs. hazard priority, memory freeze, async reset and
// counter saturation (second instance with 2-bit counters).
module tb_pipeline_hazard_ctrl;

  localparam logic [31:0] ADD_5_1_2 = 32'h002082B3;  // add x5,x1,x2
  localparam logic [31:0] SUB_6_5_3 = 32'h40328333;  // sub x6,x5,x3
  localparam logic [31:0] OR_7_5_4  = 32'h0042E3B3;  // or  x7,x5,x4
  localparam logic [31:0] LW_7_1    = 32'h0000A383;  // lw  x7,0(x1)
  localparam logic [31:0] ADD_8_7_7 = 32'h00738433;  // add x8,x7,x7
  localparam logic [31:0] LW_0_1    = 32'h0000A003;  // lw  x0,0(x1)
  localparam logic [31:0] ADD_8_0_0 = 32'h00000433;  // add x8,x0,x0

  logic clk;
  logic rst_n;
  logic rst_n_s;
  int   checks;
  int   errors;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hz1 ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  hz2 ();

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz1)
  );

  pipeline_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n_s),
    .hz    (hz2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: after the rising edge apply inputs to both instances, then
  // return at the falling edge where outputs are sampled.
  task automatic cyc(input logic [31:0] instr, input logic v, input logic br, input logic busy);
    @(posedge clk);
    #1;
    hz1.id_instr = instr; hz1.id_valid = v; hz1.ex_branch_taken = br; hz1.mem_busy = busy;
    hz2.id_instr = instr; hz2.id_valid = v; hz2.ex_branch_taken = br; hz2.mem_busy = busy;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n   = 1'b0;
    rst_n_s = 1'b0;
    hz1.id_instr = '0; hz1.id_valid = 1'b0; hz1.ex_branch_taken = 1'b0; hz1.mem_busy = 1'b0;
    hz2.id_instr = '0; hz2.id_valid = 1'b0; hz2.ex_branch_taken = 1'b0; hz2.mem_busy = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state with idle inputs
    chk("rst_pc_en",   {31'd0, hz1.pc_en},      32'd1);
    chk("rst_ifid_en", {31'd0, hz1.ifid_en},    32'd1);
    chk("rst_pipe_en", {31'd0, hz1.pipe_en},    32'd1);
    chk("rst_flushes", {30'd0, hz1.ifid_flush, hz1.idex_flush}, 32'd0);
    chk("rst_fwd",     {28'd0, hz1.fwd_a, hz1.fwd_b}, 32'd0);
    chk("rst_valids",  {29'd0, hz1.ex_valid, hz1.mem_valid, hz1.wb_valid}, 32'd0);
    chk("rst_stall",   {16'd0, hz1.stall_count}, 32'd0);
    chk("rst_flush",   {16'd0, hz1.flush_count}, 32'd0);
    #1;
    rst_n   = 1'b1;
    rst_n_s = 1'b1;

    // RAW distance 1 (MEM forward) and distance 2 (WB forward)
    cyc(ADD_5_1_2, 1'b1, 1'b0, 1'b0);
    chk("raw_pc0", {31'd0, hz1.pc_en}, 32'd1);
    cyc(SUB_6_5_3, 1'b1, 1'b0, 1'b0);
    chk("raw_pc1", {31'd0, hz1.pc_en}, 32'd1);
    cyc(OR_7_5_4, 1'b1, 1'b0, 1'b0);
    chk("raw1_fwd_a", {30'd0, hz1.fwd_a}, 32'h2);
    chk("raw1_fwd_b", {30'd0, hz1.fwd_b}, 32'h0);
    chk("raw_pc2",    {31'd0, hz1.pc_en}, 32'd1);
    idle(1);
    chk("raw2_fwd_a", {30'd0, hz1.fwd_a}, 32'h1);
    chk("raw2_fwd_b", {30'd0, hz1.fwd_b}, 32'h0);
    chk("raw_pc3",    {31'd0, hz1.pc_en}, 32'd1);
    idle(3);

    // Load-use: one stall cycle, then WB forward on both operands
    cyc(LW_7_1, 1'b1, 1'b0, 1'b0);
    cyc(ADD_8_7_7, 1'b1, 1'b0, 1'b0);
    chk("lu_pc_en",   {31'd0, hz1.pc_en},      32'd0);
    chk("lu_ifid_en", {31'd0, hz1.ifid_en},    32'd0);
    chk("lu_idex_fl", {31'd0, hz1.idex_flush}, 32'd1);
    chk("lu_pipe_en", {31'd0, hz1.pipe_en},    32'd1);
    chk("lu_stall0",  {16'd0, hz1.stall_count}, 32'd0);
    cyc(ADD_8_7_7, 1'b1, 1'b0, 1'b0);
    chk("lu_pc_en2",  {31'd0, hz1.pc_en},      32'd1);
    chk("lu_ex_bub",  {31'd0, hz1.ex_valid},   32'd0);
    chk("lu_stall1",  {16'd0, hz1.stall_count}, 32'd1);
    idle(1);
    chk("lu_fwd",     {28'd0, hz1.fwd_a, hz1.fwd_b}, 32'h5);
    idle(3);

    // x0 destination: no stall, no forwarding
    cyc(LW_0_1, 1'b1, 1'b0, 1'b0);
    cyc(ADD_8_0_0, 1'b1, 1'b0, 1'b0);
    chk("x0_pc_en",  {31'd0, hz1.pc_en},      32'd1);
    chk("x0_idex",   {31'd0, hz1.idex_flush}, 32'd0);
    idle(1);
    chk("x0_fwd",    {28'd0, hz1.fwd_a, hz1.fwd_b}, 32'h0);
    chk("x0_stall",  {16'd0, hz1.stall_count}, 32'd1);
    idle(3);

    // Branch coincident with load-use: flush wins, stall not counted
    cyc(LW_7_1, 1'b1, 1'b0, 1'b0);
    cyc(ADD_8_7_7, 1'b1, 1'b1, 1'b0);
    chk("br_pc_en",   {31'd0, hz1.pc_en},      32'd1);
    chk("br_ifid_en", {31'd0, hz1.ifid_en},    32'd1);
    chk("br_ifid_fl", {31'd0, hz1.ifid_flush}, 32'd1);
    chk("br_idex_fl", {31'd0, hz1.idex_flush}, 32'd1);
    idle(1);
    chk("br_flush1",  {16'd0, hz1.flush_count}, 32'd1);
    chk("br_stall",   {16'd0, hz1.stall_count}, 32'd1);
    chk("br_ex_bub",  {31'd0, hz1.ex_valid},   32'd0);
    idle(3);

    // Freeze for three cycles over a load-use hazard
    cyc(LW_7_1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(ADD_8_7_7, 1'b1, 1'b0, 1'b1);
      chk("fz_enables", {29'd0, hz1.pc_en, hz1.ifid_en, hz1.pipe_en}, 32'd0);
      chk("fz_flushes", {30'd0, hz1.ifid_flush, hz1.idex_flush}, 32'd0);
      chk("fz_ex_hold", {31'd0, hz1.ex_valid}, 32'd1);
      chk("fz_stall",   {16'd0, hz1.stall_count}, 32'd1);
    end
    cyc(ADD_8_7_7, 1'b1, 1'b0, 1'b0);
    chk("fz_lu_pc",   {31'd0, hz1.pc_en},      32'd0);
    chk("fz_lu_idex", {31'd0, hz1.idex_flush}, 32'd1);
    cyc(ADD_8_7_7, 1'b1, 1'b0, 1'b0);
    chk("fz_pc_back", {31'd0, hz1.pc_en},      32'd1);
    chk("fz_stall2",  {16'd0, hz1.stall_count}, 32'd2);
    idle(1);
    chk("fz_fwd",     {28'd0, hz1.fwd_a, hz1.fwd_b}, 32'h5);
    chk("sat_mid",    {30'd0, hz2.stall_count}, 32'd2);
    chk("sat_flush",  {30'd0, hz2.flush_count}, 32'd1);
    idle(3);

    // Asynchronous reset in the middle of a stall
    cyc(LW_7_1, 1'b1, 1'b0, 1'b0);
    cyc(ADD_8_7_7, 1'b1, 1'b0, 1'b0);
    chk("ar_pre_pc", {31'd0, hz1.pc_en}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valids", {29'd0, hz1.ex_valid, hz1.mem_valid, hz1.wb_valid}, 32'd0);
    chk("ar_stall",  {16'd0, hz1.stall_count}, 32'd0);
    chk("ar_flush",  {16'd0, hz1.flush_count}, 32'd0);
    chk("ar_pc_en",  {31'd0, hz1.pc_en},      32'd1);
    chk("ar_idex",   {31'd0, hz1.idex_flush}, 32'd0);
    #1 rst_n = 1'b1;
    idle(1);
    chk("ar_adv_ex", {31'd0, hz1.ex_valid}, 32'd1);
    chk("ar_adv_pc", {31'd0, hz1.pc_en},    32'd1);
    idle(3);

    // Three more load-use stalls: wide counter counts, 2-bit counter sticks
    for (int i = 0; i < 3; i++) begin
      cyc(LW_7_1, 1'b1, 1'b0, 1'b0);
      cyc(ADD_8_7_7, 1'b1, 1'b0, 1'b0);
      cyc(ADD_8_7_7, 1'b1, 1'b0, 1'b0);
      idle(2);
    end
    chk("cnt_stall3", {16'd0, hz1.stall_count}, 32'd3);
    chk("sat_stick",  {30'd0, hz2.stall_count}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Sequencing controller for the 5-stage RV32I pipeline. It sits beside the decode-stage control_unit and keeps a small scoreboard of the instructions in EX, MEM and WB. From that scoreboard it drives pipeline-register enables and flushes, and the EX operand forwarding selects. It also handles load-use stalls, taken-branch flushes and data-memory wait freezes, and keeps saturating performance counters.

Parameters:
CNT_W, 16, width of the stall_count and flush_count performance counters

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
id_instr  input  32  instruction held in IF/ID (opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20])
id_valid  input  1  id_instr is a real instruction (not a bubble)
ex_branch_taken  input  1  branch/jump resolved taken in EX; source holds it while the pipeline is frozen
mem_busy  input  1  data memory not ready; whole pipeline must freeze
pc_en  output  1  PC register load enable
ifid_en  output  1  IF/ID register load enable
ifid_flush  output  1  IF/ID loads a bubble
idex_flush  output  1  ID/EX loads a bubble
pipe_en  output  1  EX/MEM and MEM/WB load enable
fwd_a  output  2  EX operand A select: 00 regfile, 10 from MEM, 01 from WB
fwd_b  output  2  EX operand B select, same encoding
ex_valid, mem_valid, wb_valid  output  1 each  scoreboard valid bits
stall_count  output  CNT_W  load-use stall cycles, saturating
flush_count  output  CNT_W  branch flush events, saturating

Behaviour:
- Decode of id_instr (combinational):
  - writes_rd for opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111.
  - uses_rs1 for 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - uses_rs2 for 0110011, 0100011, 1100011.
  - is_load for 0000011.
  - Any other opcode: no reads, no write.
- Scoreboard entries are ex_{valid,rd,rs1,rs2,wr,ld}, mem_{valid,rd,wr,ld} and wb_{valid,rd,wr}.
  - A write with rd = 0 is stored as wr = 0.
- Per-cycle priority:
  1. mem_busy = 1: freeze.
     - pc_en = 0, ifid_en = 0, pipe_en = 0, both flushes = 0.
     - All scoreboard state and counters hold.
  2. ex_branch_taken = 1: flush.
     - pc_en = 1, ifid_en = 1, ifid_flush = 1, idex_flush = 1, pipe_en = 1.
     - Next EX entry is a bubble (valid = 0). flush_count += 1.
     - A coincident load-use hazard is ignored and not counted.
  3. Load-use: id_valid && ex_valid && ex_ld && ex_wr && ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd)).
     - pc_en = 0, ifid_en = 0, idex_flush = 1, pipe_en = 1.
     - Next EX entry is a bubble. stall_count += 1.
  4. Otherwise:
     - All enables = 1, flushes = 0.
     - EX entry loads the decoded id_instr fields, with valid = id_valid.
- Advance (when not frozen): wb <= mem, mem <= ex, then ex is loaded per the rules above.
- Forwarding (combinational from EX entry vs MEM/WB; MEM has priority):
  - fwd_a = 10 if ex_valid && mem_valid && mem_wr && !mem_ld && mem_rd == ex_rs1.
  - Else fwd_a = 01 if ex_valid && wb_valid && wb_wr && wb_rd == ex_rs1.
  - Else fwd_a = 00.
  - fwd_b is identical, using ex_rs2.
- Hazard and enable outputs are combinational in the same cycle; there is no added latency.
- Counters saturate at all-ones and do not wrap.
- Reset (asynchronous, takes effect immediately, including mid-stall or mid-freeze):
  - All valid bits, rd/rs fields and counters = 0.
  - Outputs while reset is held and inputs are idle: pc_en = 1, ifid_en = 1, pipe_en = 1, flushes = 0, fwd_a = fwd_b = 00.
  - After rst_n deasserts, the first edge behaves as normal advance.

Test Plan:
1. RAW distance 1 and 2:
   - Stimulus: add x5,x1,x2 (0x002082B3), then sub x6,x5,x3, then or x7,x5,x4.
   - Response: fwd_a = 10 when sub is in EX; fwd_a = 01 when or is in EX; pc_en stays 1 throughout.
2. Load-use:
   - Stimulus: lw x7,0(x1), then add x8,x7,x7.
   - Response: exactly one cycle with pc_en = 0, ifid_en = 0, idex_flush = 1.
   - Next cycle: fwd_a = fwd_b = 01. stall_count goes 0 → 1.
3. x0 destination:
   - Stimulus: lw x0,0(x1), then add x8,x0,x0.
   - Response: no stall; fwd_a = fwd_b = 00.
4. Branch plus hazard in the same cycle:
   - Stimulus: ex_branch_taken = 1 while a load-use condition is present.
   - Response: ifid_flush = idex_flush = 1, pc_en = 1; flush_count +1, stall_count unchanged.
5. Freeze:
   - Stimulus: mem_busy = 1 for 3 cycles during the scenario 2 hazard.
   - Response: pc_en = ifid_en = pipe_en = 0 for those cycles; scoreboard and counters hold.
   - After release: the single stall cycle occurs as in scenario 2.
6. Reset and saturation:
   - Stimulus: assert rst_n = 0 mid-stall; separately use CNT_W = 2 with 5 stalls.
   - Response: valids and counters clear immediately on reset; stall_count sticks at 3.
